hpf_coeff_load_sequencer: RTL and testbench

//  Controller for the pedestal-recovery HPF integrator bank. Holds a host-writable shadow

---
 rtl/hpf_ctrl_pkg.sv | 27 ++
 rtl/hpf_coeff_regfile.sv | 37 +++
 rtl/hpf_coeff_load_sequencer.sv | 140 ++++++++++++++
 tb/tb_hpf_coeff_load_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpf_ctrl_pkg.sv
// Shared types, sizes and power-on coefficient set for the HPF coefficient load sequencer.
package hpf_ctrl_pkg;

  localparam int NUM_COEF = 5;
  localparam int COEF_W   = 32;
  localparam int SEL_W    = 3;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_COEF - 1);

  typedef enum logic [2:0] {IDLE, RST, LOAD, SETTLE, RUN} state_t;

  typedef logic [COEF_W-1:0] coef_t;

  // Low half of slot 0 is unconstrained in the source set; it is zeroed here.
  localparam coef_t HPF_COEF_DEFAULT [NUM_COEF] = '{
    32'h0000_0000,
    32'hFFFE_2EF4,
    32'h0000_E0F9,
    32'h0001_E339,
    32'hFFFF_1C99
  };

  function automatic logic addr_valid(input logic [SEL_W-1:0] addr);
    return addr <= LAST_SEL;
  endfunction

endpackage

// File: rtl/hpf_coeff_regfile.sv
// Host-writable shadow coefficient bank with write rejection and registered readback.
module hpf_coeff_regfile
  import hpf_ctrl_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cfg_we,
  input  logic [SEL_W-1:0]                 cfg_addr,
  input  logic [COEF_W-1:0]                cfg_wdata,
  input  logic                             write_ok,
  output logic [COEF_W-1:0]                cfg_rdata,
  output logic                             cfg_err,
  output logic [NUM_COEF-1:0][COEF_W-1:0]  bank
);

  logic accept;

  assign accept = cfg_we && write_ok && addr_valid(cfg_addr);

  // Readback shows the bank contents before any write committing on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        bank[i] <= HPF_COEF_DEFAULT[i];
      end
      cfg_rdata <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err   <= cfg_we && !accept;
      cfg_rdata <= addr_valid(cfg_addr) ? bank[cfg_addr] : '0;
      if (accept) begin
        bank[cfg_addr] <= cfg_wdata;
      end
    end
  end

endmodule

// File: rtl/hpf_coeff_load_sequencer.sv
// Sequences the shadow coefficient bank into the HPF integrator bank, then gates its run enable.
// Optional HPF_CTRL_AUTOLOAD_EN: the first IDLE cycle after reset starts a load by itself.
module hpf_coeff_load_sequencer
  import hpf_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [SEL_W-1:0]  cfg_addr,
  input  logic [COEF_W-1:0] cfg_wdata,
  output logic [COEF_W-1:0] cfg_rdata,
  output logic              cfg_err,
  input  logic              load_req,
  input  logic              run_en,
  output logic              filt_reset,
  output logic [SEL_W-1:0]  filt_reg_select,
  output logic              filt_enable_reg_select,
  output logic [COEF_W-1:0] filt_coefficient,
  output logic              filt_en,
  output logic              busy,
  output logic              load_done
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t                            state;
  logic [SEL_W-1:0]                  idx;
  logic [SEL_W-1:0]                  idx_next;
  logic [CNT_W-1:0]                  settle_cnt;
  logic [NUM_COEF-1:0][COEF_W-1:0]   bank;
  logic                              write_ok;
  logic                              start;

  assign write_ok = (state == IDLE) || (state == RUN);
  assign idx_next = idx + SEL_W'(1);
  assign filt_en  = (state == RUN) && run_en;

`ifdef HPF_CTRL_AUTOLOAD_EN
  logic autoload_pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      autoload_pending <= 1'b1;
    end else begin
      autoload_pending <= 1'b0;
    end
  end

  assign start = load_req || autoload_pending;
`else
  assign start = load_req;
`endif

  hpf_coeff_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .write_ok  (write_ok),
    .cfg_rdata (cfg_rdata),
    .cfg_err   (cfg_err),
    .bank      (bank)
  );

  // Bus outputs are loaded one cycle ahead so they are valid for the whole LOAD cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= IDLE;
      idx                    <= '0;
      settle_cnt             <= '0;
      filt_reset             <= 1'b1;
      filt_reg_select        <= '0;
      filt_enable_reg_select <= 1'b0;
      filt_coefficient       <= '0;
      busy                   <= 1'b0;
      load_done              <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          filt_reset <= 1'b1;
          if (start) begin
            state <= RST;
            busy  <= 1'b1;
          end
        end
        RST: begin
          state                  <= LOAD;
          idx                    <= '0;
          filt_reset             <= 1'b0;
          filt_enable_reg_select <= 1'b1;
          filt_reg_select        <= '0;
          filt_coefficient       <= bank[0];
        end
        LOAD: begin
          if (idx == LAST_SEL) begin
            state                  <= SETTLE;
            settle_cnt             <= '0;
            filt_enable_reg_select <= 1'b0;
            filt_reg_select        <= '0;
            filt_coefficient       <= '0;
          end else begin
            idx              <= idx_next;
            filt_reg_select  <= idx_next;
            filt_coefficient <= bank[idx_next];
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state     <= RUN;
            busy      <= 1'b0;
            load_done <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (load_req) begin
            state      <= RST;
            filt_reset <= 1'b1;
            busy       <= 1'b1;
          end
        end
        default: begin
          state                  <= IDLE;
          filt_reset             <= 1'b1;
          filt_enable_reg_select <= 1'b0;
          filt_reg_select        <= '0;
          filt_coefficient       <= '0;
          busy                   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hpf_coeff_load_sequencer.sv
// Randomized self-checking bench for hpf_coeff_load_sequencer against a cycle-offset model.
// Build with HPF_CTRL_AUTOLOAD_EN defined to exercise the autoload variant.
module tb_hpf_coeff_load_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        cfg_err;
  logic        load_req;
  logic        run_en;
  logic        filt_reset;
  logic [2:0]  filt_reg_select;
  logic        filt_enable_reg_select;
  logic [31:0] filt_coefficient;
  logic        filt_en;
  logic        busy;
  logic        load_done;

  hpf_coeff_load_sequencer dut (
    .clk                    (clk),
    .reset                  (reset),
    .cfg_we                 (cfg_we),
    .cfg_addr               (cfg_addr),
    .cfg_wdata              (cfg_wdata),
    .cfg_rdata              (cfg_rdata),
    .cfg_err                (cfg_err),
    .load_req               (load_req),
    .run_en                 (run_en),
    .filt_reset             (filt_reset),
    .filt_reg_select        (filt_reg_select),
    .filt_enable_reg_select (filt_enable_reg_select),
    .filt_coefficient       (filt_coefficient),
    .filt_en                (filt_en),
    .busy                   (busy),
    .load_done              (load_done)
  );

  always #5 clk = ~clk;

  logic [31:0] tb_default [5] = '{32'h0000_0000, 32'hFFFE_2EF4, 32'h0000_E0F9,
                                  32'h0001_E339, 32'hFFFF_1C99};

  int n_checks = 0;
  int n_pass   = 0;

  // Model phase: 0 idle, 1 reset pulse, 2..6 slot writes, 7..8 settle, 9 entry to run, 10 running.
  int          m_t;
  logic [31:0] m_shadow [5];
  logic [31:0] m_rdata;
  logic        m_err;
  logic        m_first;
  int          cyc;

  logic [2:0]  cap_sel  [$];
  logic [31:0] cap_coef [$];
  int          cap_cyc  [$];
  int          done_cnt;
  int          done_cyc;
  int          err_cnt;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t     = 0;
      for (int i = 0; i < 5; i++) m_shadow[i] = tb_default[i];
      m_rdata = 32'h0;
      m_err   = 1'b0;
      m_first = 1'b1;
      cyc     = 0;
    end else begin
      bit accept;
      bit valid;
      bit req;
      accept  = (m_t == 0) || (m_t >= 9);
      valid   = (cfg_addr < 3'd5);
      m_err   = cfg_we && !(accept && valid);
      m_rdata = valid ? m_shadow[cfg_addr] : 32'h0;
      if (cfg_we && accept && valid) m_shadow[cfg_addr] = cfg_wdata;
      req = load_req;
`ifdef HPF_CTRL_AUTOLOAD_EN
      if (m_first) req = 1'b1;
`endif
      if (m_t == 0)      m_t = req ? 1 : 0;
      else if (m_t >= 9) m_t = load_req ? 1 : 10;
      else               m_t = m_t + 1;
      m_first = 1'b0;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      bit ld;
      int slot;
      ld   = (m_t >= 2) && (m_t <= 6);
      slot = ld ? (m_t - 2) : 0;
      checkOutput("filt_reset", 64'(filt_reset), 64'(m_t <= 1));
      checkOutput("enable_reg_select", 64'(filt_enable_reg_select), 64'(ld));
      checkOutput("reg_select", 64'(filt_reg_select), ld ? 64'(slot) : 64'h0);
      checkOutput("coefficient", 64'(filt_coefficient), ld ? 64'(m_shadow[slot]) : 64'h0);
      checkOutput("busy", 64'(busy), 64'((m_t >= 1) && (m_t <= 8)));
      checkOutput("load_done", 64'(load_done), 64'(m_t == 9));
      checkOutput("filt_en", 64'(filt_en), 64'((m_t >= 9) && run_en));
      checkOutput("cfg_rdata", 64'(cfg_rdata), 64'(m_rdata));
      checkOutput("cfg_err", 64'(cfg_err), 64'(m_err));
      if (filt_enable_reg_select) begin
        cap_sel.push_back(filt_reg_select);
        cap_coef.push_back(filt_coefficient);
        cap_cyc.push_back(cyc);
      end
      if (load_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cfg_err) err_cnt++;
    end
  end

  task automatic applyStimulus(input logic we, input logic [2:0] addr, input logic [31:0] wdata,
                               input logic lreq, input logic ren);
    @(negedge clk);
    #1;
    cfg_we    = we;
    cfg_addr  = addr;
    cfg_wdata = wdata;
    load_req  = lreq;
    run_en    = ren;
  endtask

  task automatic waitForRun(input int maxCycles);
    int n;
    n = 0;
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b1);
    while (m_t < 9 && n < maxCycles) begin
      applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b1);
      n++;
    end
    checkOutput("run_reached", 64'(m_t >= 9), 64'h1);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_filt_reset", 64'(filt_reset), 64'h1);
    checkOutput("rst_strobe", 64'(filt_enable_reg_select), 64'h0);
    checkOutput("rst_sel", 64'(filt_reg_select), 64'h0);
    checkOutput("rst_coef", 64'(filt_coefficient), 64'h0);
    checkOutput("rst_filt_en", 64'(filt_en), 64'h0);
    checkOutput("rst_busy", 64'(busy), 64'h0);
    checkOutput("rst_load_done", 64'(load_done), 64'h0);
    checkOutput("rst_rdata", 64'(cfg_rdata), 64'h0);
    checkOutput("rst_err", 64'(cfg_err), 64'h0);
  endtask

  task automatic clearCapture();
    cap_sel.delete();
    cap_coef.delete();
    cap_cyc.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    cfg_we = 1'b0; load_req = 1'b0; run_en = 1'b0; cfg_addr = 3'd0; cfg_wdata = 32'h0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
`ifdef HPF_CTRL_AUTOLOAD_EN
    waitForRun(30);
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int req_cyc;
    int n;
    cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 32'h0; load_req = 1'b0; run_en = 1'b0;
    reset = 1'b1;
    clearCapture();
    #2;
    $display("[TB] reset state");
    checkResetValues();
    repeat (3) @(negedge clk);
    reset = 1'b0;

`ifdef HPF_CTRL_AUTOLOAD_EN
    $display("[TB] autoload after reset");
    waitForRun(30);
    checkOutput("autoload_done_cycle", 64'(done_cyc), 64'd9);
    checkOutput("autoload_done_count", 64'(done_cnt), 64'd1);
    checkOutput("autoload_slots", 64'(cap_sel.size()), 64'd5);
`else
    $display("[TB] first load with defaults");
    repeat (3) applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
    waitForRun(30);
    checkOutput("load1_slots", 64'(cap_sel.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput("load1_sel", 64'(cap_sel[i]), 64'(i));
      checkOutput("load1_coef", 64'(cap_coef[i]), 64'(tb_default[i]));
    end
    checkOutput("load1_first_strobe", 64'(cap_cyc[0]), 64'd6);
    checkOutput("load1_done_cycle", 64'(done_cyc), 64'd13);
`endif
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, i[0]);

    $display("[TB] shadow write then reload");
    doReset();
    applyStimulus(1'b1, 3'd2, 32'h1234_5678, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd2, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("rdata_slot2", 64'(cfg_rdata), 64'h1234_5678);
    clearCapture();
    applyStimulus(1'b0, 3'd2, 32'h0, 1'b1, 1'b1);
    waitForRun(30);
    checkOutput("load2_slots", 64'(cap_coef.size()), 64'd5);
    checkOutput("load2_slot2", 64'(cap_coef[2]), 64'h1234_5678);

    $display("[TB] rejected writes");
    clearCapture();
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'd3, 32'hDEAD_BEEF, 1'b0, 1'b1);
    waitForRun(30);
    applyStimulus(1'b1, 3'd6, 32'hCAFE_F00D, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'd3, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("err_pulses", 64'(err_cnt), 64'd2);
    checkOutput("rdata_slot3_kept", 64'(cfg_rdata), 64'h0001_E339);

    $display("[TB] reload from run");
    clearCapture();
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 1'b1);
    req_cyc = cyc;
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b1);
    checkOutput("reload_filt_en_drop", 64'(filt_en), 64'h0);
    waitForRun(30);
    checkOutput("reload_latency", 64'(done_cyc - req_cyc), 64'd9);
    checkOutput("reload_slots", 64'(cap_sel.size()), 64'd5);

    $display("[TB] async reset mid-load");
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 1'b1);
    n = 0;
    while (m_t != 4 && n < 10) begin
      applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b1);
      n++;
    end
    checkOutput("reached_slot2", 64'(m_t), 64'd4);
    #1;
    reset = 1'b1;
    #1;
    checkResetValues();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clearCapture();
`ifdef HPF_CTRL_AUTOLOAD_EN
    waitForRun(30);
`else
    repeat (20) applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b1);
    checkOutput("no_strobes_after_reset", 64'(cap_sel.size()), 64'd0);
`endif
    applyStimulus(1'b0, 3'd2, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("rdata_slot2_default", 64'(cfg_rdata), 64'h0000_E0F9);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) == 0, 3'($urandom % 8), $urandom,
                    ($urandom % 12) == 0, ($urandom % 4) != 0);
    end

`ifndef HPF_CTRL_AUTOLOAD_EN
    $display("[TB] idle hold without load request");
    doReset();
    clearCapture();
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 3'($urandom % 8), 32'h0, 1'b0, ($urandom % 2) == 0);
    end
    checkOutput("idle_no_strobes", 64'(cap_sel.size()), 64'd0);
    checkOutput("idle_no_done", 64'(done_cnt), 64'd0);
    checkOutput("idle_filt_reset", 64'(filt_reset), 64'h1);
`endif

    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
